rvs_replace_unit: RTL and testbench
===================================

Name: rvs_replace_unit

Overview:
Second-generation L1 cache victim-selection unit for RVS192 I/D caches. Keeps replacement state per set for a parametrised number of ways and sets. Supports three compile-time policies: LFSR random, per-set round-robin and tree pseudo-LRU. Sits beside the tag array: it receives a lookup (set, valid, hit) and returns a registered one-hot victim. It receives fill/touch updates from the cache controller and provides a sequenced flush.

Parameters:
- WAY_NUM, 4, number of ways; power of two, 2..16.
- SET_NUM, 128, number of sets; power of two.
- MODE, 2, replacement policy: 0 = LFSR random, 1 = round-robin, 2 = tree-PLRU.
- LFSR_W, 16, LFSR width for MODE 0; taps come from a package table.

Ports:
- clk_l1  in  1  cache clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  lookup request.
- req_set  in  log2(SET_NUM)  lookup set index.
- valid  in  WAY_NUM  valid bits of the addressed set.
- hit  in  WAY_NUM  one-hot hit vector; all zero means miss.
- victim_valid  out  1  victim_way is meaningful.
- victim_way  out  WAY_NUM  one-hot victim.
- fill_valid  in  1  line-fill completion.
- fill_set  in  log2(SET_NUM)  set of the fill.
- fill_way  in  WAY_NUM  one-hot way filled.
- flush  in  1  one-cycle pulse: clear all per-set state.
- busy  out  1  flush in progress.

Behaviour:
- Reset is asynchronous active-low, using clk_l1 and rst_n only.
  - State array cleared to 0, LFSR loaded with 1, FSM in IDLE.
  - victim_valid=0, victim_way=0, busy=0.
- Lookup latency is 1 cycle. When req_valid=1 in cycle N in IDLE, victim_valid and victim_way are registered at edge N+1 and hold for exactly one cycle.
  - If hit!=0: victim_valid=0, victim_way=0. The set's state is touched with the hit way.
  - Miss with any valid bit 0: victim is the lowest-index invalid way.
  - Miss with all valid: victim comes from the policy.
    - MODE0: victim = 1<<lfsr[log2(WAY_NUM)-1:0].
    - MODE1: victim = 1<<ptr[set].
    - MODE2: victim comes from a PLRU tree walk.
- Multi-bit hit (illegal): the lowest set bit is used.
- LFSR: Galois, advances only on cycles with req_valid & miss in IDLE. It never reaches 0.
- Per-set state width: MODE0 = none, MODE1 = log2(WAY_NUM) bits, MODE2 = WAY_NUM-1 bits.
- PLRU node rules:
  - Node bit 0 points to the lower half.
  - A touch of way w sets every node on w's path to point away from w.
  - The walk follows node bits to a leaf.
- Touch sources:
  - A hit touches req_set at edge N+1.
  - fill_valid touches fill_set with fill_way in the same cycle.
  - In MODE1, a fill sets ptr[fill_set] = (index(fill_way)+1) mod WAY_NUM. Hits do not change ptr.
- Simultaneous hit-touch and fill to the same set: the fill update is applied last (fill wins). Different sets are both updated.
- Lookup of a set being updated in the same cycle uses the pre-update state. There is no bypass.
- FSM has two states, IDLE and FLUSH.
  - flush in IDLE → FLUSH. A counter walks sets 0..SET_NUM-1, clearing one set per cycle, then returns to IDLE. Duration is SET_NUM cycles.
  - busy=1 throughout FLUSH.
  - req_valid and fill_valid are ignored while busy; victim_valid stays 0.
  - flush during FLUSH is ignored. The LFSR is not reset by flush.
- Reset asserted mid-flush aborts immediately to the reset state.

Optional Feature:
RVS_REPLACE_STAT_EN.
- Defined: adds outputs stat_miss_cnt[31:0] and stat_evict_cnt[31:0].
  - stat_miss_cnt counts lookups with hit==0.
  - stat_evict_cnt counts misses whose victim came from the policy (all ways valid).
  - Both counters are saturating, reset to 0 by rst_n and not cleared by flush.
- Undefined: the ports and logic are absent.

Decomposition:
- Package rvs_replace_pkg holds:
  - the policy enum (REP_RANDOM, REP_RR, REP_PLRU);
  - the FSM state typedef (ST_IDLE, ST_FLUSH);
  - the LFSR tap constant function per width;
  - helper functions onehot2idx and plru_walk/plru_touch.
- One sub-module, rvs_lfsr: parametrised Galois LFSR with enable and nonzero seed.

Test Plan:
- Reset, MODE2, WAY_NUM=4 → victim_valid=0, busy=0. Miss on set 5 with valid=4'b1111 → victim_way=4'b0001 one cycle later.
- MODE2, set 5 all valid: hit=4'b0001, then miss → victim 4'b0100. Then hit=4'b0100, then miss → victim 4'b0010.
- Miss on set 3 with valid=4'b1011 → victim 4'b0100 regardless of MODE. A second lookup with hit=4'b0010 → victim_valid=0.
- MODE1: fill set 7 way 4'b1000, then miss with all valid → victim 4'b0001 (wrap-around). Simultaneous hit-touch and fill on set 7 → state reflects the fill.
- flush pulse with SET_NUM=128 → busy high for exactly 128 cycles; req_valid during busy gives victim_valid=0; afterwards PLRU sets report victim 4'b0001. Asserting rst_n low at cycle 40 of the flush → busy=0 immediately.
- MODE0: 1000 all-valid misses → every way chosen at least once, victim never 0. With RVS_REPLACE_STAT_EN, stat_miss_cnt=1000 and stat_evict_cnt=1000.

Source files
------------

// File: rtl/rvs_replace_pkg.sv
// Shared types and helpers for the RVS192 L1 victim-selection unit:
// policy/FSM encodings, Galois LFSR tap table, one-hot and PLRU tree helpers.
package rvs_replace_pkg;

    typedef enum logic [1:0] {
        REP_RANDOM = 2'd0,
        REP_RR     = 2'd1,
        REP_PLRU   = 2'd2
    } rep_policy_e;

    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 1'b0;
    localparam fsm_state_t ST_FLUSH = 1'b1;

    // Right-shift Galois masks of maximal-length polynomials, bit k-1 = x^k term.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] t;
        case (width)
            2:       t = 32'h0000_0003;
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_B400;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_B400;
        endcase
        return t;
    endfunction

    // Lowest set bit wins, so an illegal multi-hot vector resolves deterministically.
    function automatic logic [3:0] onehot2idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [3:0] plru_walk(input logic [14:0] nodes, input int levels);
        logic [3:0] idx;
        int         n;
        idx = 4'd0;
        n   = 0;
        for (int l = 0; l < 4; l++) begin
            if (l < levels) begin
                idx = {idx[2:0], nodes[n]};
                n   = 2 * n + 1 + (nodes[n] ? 1 : 0);
            end
        end
        return idx;
    endfunction

    function automatic logic [14:0] plru_touch(input logic [14:0] nodes, input logic [3:0] way,
                                               input int levels);
        logic [14:0] res;
        logic        d;
        int          n;
        res = nodes;
        n   = 0;
        for (int l = 0; l < 4; l++) begin
            if (l < levels) begin
                d      = way[levels - 1 - l];
                res[n] = ~d;
                n      = 2 * n + 1 + (d ? 1 : 0);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rvs_replace_unit_lfsr.sv
// Galois LFSR with advance enable; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module rvs_lfsr
    import rvs_replace_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         clk_l1,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] lfsr
);

    localparam logic [31:0]  TAPS_ALL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];
    localparam logic [W-1:0] SEED_NZ  = (SEED == '0) ? W'(1) : SEED;

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_NZ;
        end else if (en) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/rvs_replace_unit.sv
// RVS192 L1 victim-selection unit: per-set replacement state (random / RR / tree-PLRU),
// registered one-hot victim, sequenced flush. Optional RVS_REPLACE_STAT_EN adds counters.
module rvs_replace_unit
    import rvs_replace_pkg::*;
#(
    parameter int WAY_NUM = 4,
    parameter int SET_NUM = 128,
    parameter int MODE    = 2,
    parameter int LFSR_W  = 16
) (
    input  logic                       clk_l1,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [$clog2(SET_NUM)-1:0] req_set,
    input  logic [WAY_NUM-1:0]         valid,
    input  logic [WAY_NUM-1:0]         hit,
    output logic                       victim_valid,
    output logic [WAY_NUM-1:0]         victim_way,
    input  logic                       fill_valid,
    input  logic [$clog2(SET_NUM)-1:0] fill_set,
    input  logic [WAY_NUM-1:0]         fill_way,
    input  logic                       flush,
    output logic                       busy
`ifdef RVS_REPLACE_STAT_EN
    ,
    output logic [31:0]                stat_miss_cnt,
    output logic [31:0]                stat_evict_cnt
`endif
);

    localparam int          IDX_W  = $clog2(WAY_NUM);
    localparam int          SET_W  = $clog2(SET_NUM);
    localparam rep_policy_e POLICY = rep_policy_e'(MODE);

    fsm_state_t       state;
    logic [SET_W-1:0] flush_cnt;
    logic             idle;
    logic             is_hit;
    logic             all_valid;
    logic             miss;
    logic [3:0]       hit_idx;
    logic [3:0]       inv_idx;
    logic [3:0]       fill_idx;
    logic [IDX_W-1:0] policy_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             unused_ok;

    assign idle       = (state == ST_IDLE);
    assign busy       = (state == ST_FLUSH);
    assign is_hit     = |hit;
    assign all_valid  = &valid;
    assign miss       = req_valid & idle & ~is_hit;
    assign hit_idx    = onehot2idx(16'(hit));
    assign inv_idx    = onehot2idx(16'(~valid));
    assign fill_idx   = onehot2idx(16'(fill_way));
    assign victim_idx = all_valid ? policy_idx : inv_idx[IDX_W-1:0];
    assign unused_ok  = ^{hit_idx, inv_idx, fill_idx, fill_set, fill_valid};

    // state | meaning
    // IDLE  | lookups, hit touches and fills accepted
    // FLUSH | flush_cnt walks sets 0..SET_NUM-1 clearing one per cycle
    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == SET_W'(SET_NUM - 1)) state <= ST_IDLE;
                    flush_cnt <= flush_cnt + SET_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            victim_valid <= miss;
            victim_way   <= miss ? (WAY_NUM'(1) << victim_idx) : '0;
        end
    end

    generate
        if (POLICY == REP_RANDOM) begin : g_random
            logic [LFSR_W-1:0] lfsr_q;
            logic              unused_lfsr;

            rvs_lfsr #(
                .W    (LFSR_W),
                .SEED (LFSR_W'(1))
            ) u_lfsr (
                .clk_l1 (clk_l1),
                .rst_n  (rst_n),
                .en     (miss),
                .lfsr   (lfsr_q)
            );

            assign policy_idx  = lfsr_q[IDX_W-1:0];
            assign unused_lfsr = ^lfsr_q;
        end else begin : g_state
            localparam int ST_W = (POLICY == REP_RR) ? IDX_W : WAY_NUM - 1;

            logic [ST_W-1:0] rep_state [SET_NUM];
            logic [ST_W-1:0] req_st;
            logic [ST_W-1:0] fill_st;
            logic [ST_W-1:0] hit_next;
            logic [ST_W-1:0] fill_next;

            assign req_st  = rep_state[req_set];
            assign fill_st = rep_state[fill_set];

            if (POLICY == REP_RR) begin : g_rr
                logic unused_rr;
                assign policy_idx = req_st;
                assign hit_next   = req_st;
                assign fill_next  = IDX_W'(fill_idx) + IDX_W'(1);
                assign unused_rr  = ^fill_st;
            end else begin : g_plru
                assign policy_idx = IDX_W'(plru_walk(15'(req_st), IDX_W));
                assign hit_next   = ST_W'(plru_touch(15'(req_st), hit_idx, IDX_W));
                assign fill_next  = ST_W'(plru_touch(15'(fill_st), fill_idx, IDX_W));
            end

            // Fill is written after the hit touch so it wins on a same-set collision.
            always_ff @(posedge clk_l1 or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SET_NUM; s++) rep_state[s] <= '0;
                end else if (!idle) begin
                    rep_state[flush_cnt] <= '0;
                end else begin
                    if (POLICY != REP_RR && req_valid && is_hit) rep_state[req_set] <= hit_next;
                    if (fill_valid) rep_state[fill_set] <= fill_next;
                end
            end
        end
    endgenerate

`ifdef RVS_REPLACE_STAT_EN
    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            stat_miss_cnt  <= '0;
            stat_evict_cnt <= '0;
        end else begin
            if (miss && stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + 32'd1;
            if (miss && all_valid && stat_evict_cnt != '1) stat_evict_cnt <= stat_evict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rvs_replace_unit.sv
// Directed bench for rvs_replace_unit: three instances (PLRU, RR, random) share stimulus.
module tb_rvs_replace_unit;
    import rvs_replace_pkg::*;

    logic       clk_l1 = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [6:0] req_set;
    logic [3:0] valid;
    logic [3:0] hit;
    logic       fill_valid;
    logic [6:0] fill_set;
    logic [3:0] fill_way;
    logic       flush;

    logic       vv_p, vv_r, vv_q;
    logic [3:0] vw_p, vw_r, vw_q;
    logic       busy_p, busy_r, busy_q;
`ifdef RVS_REPLACE_STAT_EN
    logic [31:0] sm_p, se_p, sm_r, se_r, sm_q, se_q;
`endif

    int errors = 0;
    int checks = 0;
    int exp_miss = 0;
    int exp_evict = 0;

    always #5 clk_l1 = ~clk_l1;

    rvs_replace_unit #(.WAY_NUM(4), .SET_NUM(128), .MODE(2), .LFSR_W(16)) u_plru (
        .clk_l1(clk_l1), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .valid(valid), .hit(hit), .victim_valid(vv_p), .victim_way(vw_p),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .flush(flush), .busy(busy_p)
`ifdef RVS_REPLACE_STAT_EN
        , .stat_miss_cnt(sm_p), .stat_evict_cnt(se_p)
`endif
    );

    rvs_replace_unit #(.WAY_NUM(4), .SET_NUM(128), .MODE(1), .LFSR_W(16)) u_rr (
        .clk_l1(clk_l1), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .valid(valid), .hit(hit), .victim_valid(vv_r), .victim_way(vw_r),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .flush(flush), .busy(busy_r)
`ifdef RVS_REPLACE_STAT_EN
        , .stat_miss_cnt(sm_r), .stat_evict_cnt(se_r)
`endif
    );

    rvs_replace_unit #(.WAY_NUM(4), .SET_NUM(128), .MODE(0), .LFSR_W(16)) u_rnd (
        .clk_l1(clk_l1), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .valid(valid), .hit(hit), .victim_valid(vv_q), .victim_way(vw_q),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .flush(flush), .busy(busy_q)
`ifdef RVS_REPLACE_STAT_EN
        , .stat_miss_cnt(sm_q), .stat_evict_cnt(se_q)
`endif
    );

    typedef struct packed {
        logic [6:0] set;
        logic [3:0] valid;
        logic [3:0] hit;
        logic       fv;
        logic [6:0] fset;
        logic [3:0] fway;
        logic       exp_vv;
        logic [3:0] exp_way;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid  = 1'b0;
        req_set    = '0;
        valid      = '0;
        hit        = '0;
        fill_valid = 1'b0;
        fill_set   = '0;
        fill_way   = '0;
        flush      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_l1);
        #1;
    endtask

    // One-cycle lookup (optionally with a fill); results are sampled after the edge.
    task automatic lookup(input logic [6:0] s, input logic [3:0] v, input logic [3:0] h,
                          input logic fv, input logic [6:0] fs, input logic [3:0] fw);
        req_valid  = 1'b1;
        req_set    = s;
        valid      = v;
        hit        = h;
        fill_valid = fv;
        fill_set   = fs;
        fill_way   = fw;
        if (h == 4'b0000) begin
            exp_miss++;
            if (v == 4'b1111) exp_evict++;
        end
        step();
        clear_inputs();
    endtask

    task automatic fill_only(input logic [6:0] fs, input logic [3:0] fw);
        fill_valid = 1'b1;
        fill_set   = fs;
        fill_way   = fw;
        step();
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [3:0] seen;

        vecs[0]  = '{7'd5,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0001};
        vecs[1]  = '{7'd5,  4'b1111, 4'b0001, 1'b0, 7'd0,  4'b0000, 1'b0, 4'b0000};
        vecs[2]  = '{7'd5,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[3]  = '{7'd5,  4'b1111, 4'b0100, 1'b0, 7'd0,  4'b0000, 1'b0, 4'b0000};
        vecs[4]  = '{7'd5,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0010};
        vecs[5]  = '{7'd5,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0010};
        vecs[6]  = '{7'd3,  4'b1011, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[7]  = '{7'd3,  4'b1111, 4'b0010, 1'b0, 7'd0,  4'b0000, 1'b0, 4'b0000};
        vecs[8]  = '{7'd3,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[9]  = '{7'd9,  4'b1111, 4'b0110, 1'b0, 7'd0,  4'b0000, 1'b0, 4'b0000};
        vecs[10] = '{7'd9,  4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[11] = '{7'd10, 4'b0000, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0001};
        vecs[12] = '{7'd10, 4'b0111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b1000};
        vecs[13] = '{7'd20, 4'b1111, 4'b0000, 1'b1, 7'd20, 4'b0001, 1'b1, 4'b0001};
        vecs[14] = '{7'd20, 4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[15] = '{7'd22, 4'b1111, 4'b0001, 1'b1, 7'd23, 4'b0001, 1'b0, 4'b0000};
        vecs[16] = '{7'd22, 4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};
        vecs[17] = '{7'd23, 4'b1111, 4'b0000, 1'b0, 7'd0,  4'b0000, 1'b1, 4'b0100};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_l1);
        #1;
        rst_n = 1'b1;
        check("reset_vv", 32'({vv_p, vv_r, vv_q}), 32'd0);
        check("reset_way", 32'({vw_p, vw_r, vw_q}), 32'd0);
        check("reset_busy", 32'({busy_p, busy_r, busy_q}), 32'd0);

        // PLRU table
        for (int i = 0; i < 18; i++) begin
            lookup(vecs[i].set, vecs[i].valid, vecs[i].hit, vecs[i].fv, vecs[i].fset, vecs[i].fway);
            check($sformatf("plru_vec%0d_vv", i), 32'(vv_p), 32'(vecs[i].exp_vv));
            check($sformatf("plru_vec%0d_way", i), 32'(vw_p), 32'(vecs[i].exp_way));
        end
        step();
        check("plru_hold_one_cycle", 32'({vv_p, vw_p}), 32'd0);

        // Round-robin sequences
        lookup(7'd8, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("rr_untouched", 32'(vw_r), 32'b0001);
        fill_only(7'd7, 4'b0010);
        lookup(7'd7, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("rr_after_fill_w1", 32'(vw_r), 32'b0100);
        fill_only(7'd7, 4'b1000);
        lookup(7'd7, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("rr_wrap", 32'(vw_r), 32'b0001);
        lookup(7'd7, 4'b1111, 4'b0100, 1'b0, 7'd0, 4'b0000);
        check("rr_hit_vv", 32'(vv_r), 32'd0);
        lookup(7'd7, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("rr_hit_no_ptr_change", 32'(vw_r), 32'b0001);
        lookup(7'd7, 4'b1111, 4'b0010, 1'b1, 7'd7, 4'b0001);
        lookup(7'd7, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("rr_hit_fill_collision", 32'(vw_r), 32'b0010);
        step();
        check("rr_hold_one_cycle", 32'({vv_r, vw_r}), 32'd0);

        // Full flush with lookups, fills and a second flush pulse while busy
        flush = 1'b1;
        step();
        flush = 1'b0;
        n   = 0;
        bad = 0;
        while (busy_p === 1'b1 && n < 400) begin
            n++;
            req_valid  = 1'b1;
            req_set    = 7'd5;
            valid      = 4'b1111;
            fill_valid = 1'b1;
            fill_set   = 7'd40;
            fill_way   = 4'b0001;
            flush      = (n == 60);
            step();
            if (vv_p !== 1'b0 || vv_r !== 1'b0 || vv_q !== 1'b0) bad++;
        end
        clear_inputs();
        check("flush_busy_cycles", 32'(n), 32'd128);
        check("flush_no_victim", 32'(bad), 32'd0);
        check("flush_busy_end", 32'({busy_p, busy_r, busy_q}), 32'd0);
        lookup(7'd5, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("post_flush_plru5", 32'(vw_p), 32'b0001);
        lookup(7'd40, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("post_flush_fill_ignored", 32'(vw_p), 32'b0001);
        lookup(7'd7, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("post_flush_rr7", 32'(vw_r), 32'b0001);

        // Reset in the middle of a flush; set 50 is touched so only reset can clear it
        lookup(7'd50, 4'b1111, 4'b0001, 1'b0, 7'd0, 4'b0000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (39) step();
        check("midflush_busy_before", 32'(busy_p), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midflush_reset_busy", 32'({busy_p, busy_r, busy_q}), 32'd0);
        check("midflush_reset_vv", 32'({vv_p, vv_r, vv_q}), 32'd0);
        exp_miss  = 0;
        exp_evict = 0;
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_busy", 32'(busy_p), 32'd0);
        lookup(7'd50, 4'b1111, 4'b0000, 1'b0, 7'd0, 4'b0000);
        check("post_reset_plru50", 32'(vw_p), 32'b0001);

        // Random policy: back-to-back all-valid misses
        bad  = 0;
        seen = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            req_valid = 1'b1;
            req_set   = 7'(i % 128);
            valid     = 4'b1111;
            hit       = 4'b0000;
            exp_miss++;
            exp_evict++;
            step();
            if (vv_q !== 1'b1 || vw_q == 4'b0000 || !$onehot(vw_q)) bad++;
            seen = seen | vw_q;
        end
        clear_inputs();
        step();
        check("rnd_victim_onehot", 32'(bad), 32'd0);
        check("rnd_all_ways_seen", 32'(seen), 32'b1111);
`ifdef RVS_REPLACE_STAT_EN
        check("stat_miss_cnt", sm_q, 32'(exp_miss));
        check("stat_evict_cnt", se_q, 32'(exp_evict));
        check("stat_miss_cnt_plru", sm_p, 32'(exp_miss));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
